// File: rtl/md_seq_ctrl_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: operation codes, FSM states
// and small opcode decode helpers.
package md_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULT  = 2'b00,
    MD_OP_MULTU = 2'b01,
    MD_OP_DIV   = 2'b10,
    MD_OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_PREP = 2'b01,
    MD_BUSY = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_div(input md_op_e op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_OP_MULT) || (op == MD_OP_DIV);
  endfunction

endpackage

// File: rtl/md_seq_ctrl_iter.sv
// md_iter_unit: one combinational step of the iterative datapath, either a
// shift-add multiply step or a restoring shift-subtract divide step.
module md_iter_unit #(
  parameter int DW = 32
) (
  input  logic          is_div,
  input  logic [DW-1:0] acc_hi,
  input  logic [DW-1:0] acc_lo,
  input  logic [DW-1:0] operand,
  output logic [DW-1:0] hi_next,
  output logic [DW-1:0] lo_next
);
  logic [DW:0]   sum;
  logic [DW:0]   rem_sh;
  logic [DW-1:0] diff;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
    hi_next = acc_hi;
    lo_next = acc_lo;
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc_hi, acc_lo[DW-1]};
    // The remainder after subtraction is always below the divisor, so DW bits suffice.
    diff    = rem_sh[DW-1:0] - operand;
    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        hi_next = diff;
        lo_next = {acc_lo[DW-2:0], 1'b1};
      end else begin
        hi_next = rem_sh[DW-1:0];
        lo_next = {acc_lo[DW-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[DW:1];
      lo_next = {sum[0], acc_lo[DW-1:1]};
    end
  end

endmodule

// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl: HI/LO multiply/divide sequencer (IDLE->PREP->BUSY->DONE) with sign fix-up.
// Define MD_FAST_MUL_EN to compute mult/multu with a single-cycle combinational multiply.
module md_seq_ctrl
  import md_seq_ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] src_a,
  input  logic [DW-1:0] src_b,
  input  logic          cancel,
  output logic          stallreq,
  output logic          hi_we,
  output logic          lo_we,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);
  md_state_e        state;
  logic             is_div;
  logic             sign_a;
  logic             sign_b;
  logic [DW-1:0]    mag_a;
  logic [DW-1:0]    mag_b;
  logic [DW-1:0]    acc_hi;
  logic [DW-1:0]    acc_lo;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             in_signed;
  logic             in_neg_a;
  logic             in_neg_b;
  logic [DW-1:0]    step_hi;
  logic [DW-1:0]    step_lo;
  logic [DW-1:0]    fix_hi;
  logic [DW-1:0]    fix_lo;

  assign accept    = start & ~cancel;
  assign in_signed = op_is_signed(md_op_e'(op));
  assign in_neg_a  = in_signed & src_a[DW-1];
  assign in_neg_b  = in_signed & src_b[DW-1];

  md_iter_unit #(.DW(DW)) u_iter (
    .is_div  (is_div),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (is_div ? mag_b : mag_a),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign fix-up is applied to the final iteration's result on the edge into DONE.
  always_comb begin
    fix_hi = step_hi;
    fix_lo = step_lo;
    if (is_div) begin
      if (sign_a ^ sign_b) fix_lo = -step_lo;
      if (sign_a)          fix_hi = -step_hi;
    end else if (sign_a ^ sign_b) begin
      {fix_hi, fix_lo} = -{step_hi, step_lo};
    end
  end

  // The op's own issue cycle must already stall EX, so IDLE looks at start directly.
  always_comb begin
    stallreq = 1'b0;
    case (state)
      MD_IDLE:          stallreq = accept;
      MD_PREP, MD_BUSY: stallreq = ~cancel;
      default:          stallreq = 1'b0;
    endcase
  end

`ifdef MD_FAST_MUL_EN
  logic [2*DW-1:0] fast_prod;
  assign fast_prod = {{DW{in_neg_a}}, src_a} * {{DW{in_neg_b}}, src_b};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_we  <= 1'b0;
      lo_we  <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            is_div <= op_is_div(md_op_e'(op));
            sign_a <= in_neg_a;
            sign_b <= in_neg_b;
            mag_a  <= in_neg_a ? -src_a : src_a;
            mag_b  <= in_neg_b ? -src_b : src_b;
`ifdef MD_FAST_MUL_EN
            if (!op_is_div(md_op_e'(op))) begin
              {hi_o, lo_o} <= fast_prod;
              hi_we        <= 1'b1;
              lo_we        <= 1'b1;
              state        <= MD_DONE;
            end else begin
              state <= MD_PREP;
            end
`else
            state <= MD_PREP;
`endif
          end
        end
        MD_PREP: begin
          if (cancel) begin
            state <= MD_IDLE;
          end else begin
            acc_hi <= '0;
            acc_lo <= is_div ? mag_a : mag_b;
            cnt    <= '0;
            if (is_div && (mag_b == '0)) begin
              // Divide by zero hands back the original dividend in HI.
              hi_o  <= sign_a ? -mag_a : mag_a;
              lo_o  <= '1;
              hi_we <= 1'b1;
              lo_we <= 1'b1;
              state <= MD_DONE;
            end else begin
              state <= MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          if (cancel) begin
            state <= MD_IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(DW - 1)) begin
              hi_o  <= fix_hi;
              lo_o  <= fix_lo;
              hi_we <= 1'b1;
              lo_we <= 1'b1;
              state <= MD_DONE;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Self-checking bench for md_seq_ctrl: directed corner cases, cancel/reset aborts and
// randomized ops compared against a plain-arithmetic 64-bit reference model.
module tb_md_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stallreq;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int tests = 0;
  int fails = 0;

  md_seq_ctrl #(.DW(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .stallreq (stallreq),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  // Reference model: MIPS HI/LO semantics computed with native 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              ia, ib, q, m;
    logic [63:0]     r;
    ia = a;
    ib = b;
    r  = '0;
    case (o)
      2'b00: begin sp = longint'(ia) * longint'(ib); r = sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; r = up; end
      2'b10: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else begin q = ia / ib; m = ia % ib; r = {m, q}; end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b);
    if (o[1] && b == 32'd0) return 2;
`ifdef MD_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issues one op and checks issue-cycle stall, latency, stall during the op, the write and its single-cycle strobe.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ex_hi, input logic [31:0] ex_lo, input bit noise);
    int lat;
    int exp_lat;
    bit stall_ok;
    exp_lat = ref_latency(o, b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; cancel = 1'b0;
    #1;
    tests++;
    if (stallreq !== 1'b1) begin
      fails++; $display("FAIL %s issue_stall got %b want 1", name, stallreq);
    end
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom;
    lat = 1; stall_ok = 1'b1;
    while (hi_we !== 1'b1 && lat < 100) begin
      if (stallreq !== 1'b1) stall_ok = 1'b0;
      if (noise) begin start = 1'($urandom_range(0, 1)); op = 2'($urandom); end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    tests++;
    if (lat != exp_lat) begin
      fails++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    end
    tests++;
    if (!stall_ok) begin
      fails++; $display("FAIL %s busy_stall got dropped want held", name);
    end
    tests++;
    if (lo_we !== 1'b1) begin
      fails++; $display("FAIL %s lo_we got %b want 1", name, lo_we);
    end
    tests++;
    if (hi_o !== ex_hi || lo_o !== ex_lo) begin
      fails++; $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h", name, hi_o, lo_o, ex_hi, ex_lo);
    end
    tests++;
    if (stallreq !== 1'b0) begin
      fails++; $display("FAIL %s done_stall got %b want 0", name, stallreq);
    end
    @(posedge clk); #1;
    tests++;
    if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
      fails++; $display("FAIL %s strobe_width got hi_we=%b lo_we=%b want 0/0", name, hi_we, lo_we);
    end
  endtask

  // Watches a window of cycles; no write strobe and no stall may appear while idle.
  task automatic expect_quiet(input string name, input int cycles);
    bit quiet;
    quiet = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (hi_we !== 1'b0 || lo_we !== 1'b0 || stallreq !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++; $display("FAIL %s quiet got activity want none", name);
    end
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if (stallreq !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      fails++;
      $display("FAIL %s reset_values got stall=%b hi_we=%b lo_we=%b hi=%h lo=%h want all 0",
               name, stallreq, hi_we, lo_we, hi_o, lo_o);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;
    expect_quiet("reset_idle", 5);
  endtask

  task automatic test_directed;
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    run_op("div_by0_neg", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("mult_neg3_5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
  endtask

  task automatic test_cancel;
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = $urandom; src_b = 32'd7; cancel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    cancel = 1'b1;
    #1;
    tests++;
    if (stallreq !== 1'b0) begin
      fails++; $display("FAIL cancel_busy stall got %b want 0", stallreq);
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    expect_quiet("cancel_busy", 40);
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd9; src_b = 32'd9;
    #1;
    tests++;
    if (stallreq !== 1'b0) begin
      fails++; $display("FAIL cancel_issue stall got %b want 0", stallreq);
    end
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    expect_quiet("cancel_issue", 40);
    run_op("after_cancel", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; cancel = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("reset_midop");
    rst = 1'b1;
    expect_quiet("reset_midop", 40);
    run_op("multu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] r;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = pick_operand();
      b = pick_operand();
      r = ref_result(o, a, b);
      run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, r[63:32], r[31:0], 1'(i % 2));
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      r = ref_result(2'(i), 32'hFFFF_FF00 + 32'(i), 32'd3 + 32'(i));
      run_op($sformatf("b2b%0d", i), 2'(i), 32'hFFFF_FF00 + 32'(i), 32'd3 + 32'(i), r[63:32], r[31:0], 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cancel();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
